mod_reduce_seq: RTL and testbench

Parametrised iterative modular reducer computing r = a mod q by restoring shift-subtract, one dividend bit per clock. It generalises the 12-bit repeated-subtraction reducer: independent dividend and modulus widths, bounded latency, valid/ready handshakes on both sides, and a zero-modulus error flag. It sits behind the NTT butterfly multipliers and reduces full-width products, e.g. a 24-bit a with q = 3329.

---
 rtl/mod_reduce_seq_if.sv | 27 ++
 rtl/mod_reduce_seq.sv | 119 +++++++++++
 tb/tb_mod_reduce_seq.sv | 125 ++++++++++++
 3 files changed

// File: rtl/mod_reduce_seq_if.sv
// mod_reduce_seq_if: operand/result handshake bundle for mod_reduce_seq.
//   in_valid_i / in_ready_o  : operand pair handshake (a_i dividend, q_i modulus)
//   out_valid_o / out_ready_i: result handshake (amodq_o remainder, err_o zero-modulus flag)
// master: producer/consumer side; slave: the reducer.
interface mod_reduce_seq_if #(
  parameter int A_WIDTH = 24,
  parameter int Q_WIDTH = 12
);
  logic               in_valid_i;
  logic               in_ready_o;
  logic [A_WIDTH-1:0] a_i;
  logic [Q_WIDTH-1:0] q_i;
  logic               out_valid_o;
  logic               out_ready_i;
  logic [Q_WIDTH-1:0] amodq_o;
  logic               err_o;

  modport master (
    output in_valid_i, a_i, q_i, out_ready_i,
    input  in_ready_o, out_valid_o, amodq_o, err_o
  );

  modport slave (
    input  in_valid_i, a_i, q_i, out_ready_i,
    output in_ready_o, out_valid_o, amodq_o, err_o
  );
endinterface

// File: rtl/mod_reduce_seq.sv
// mod_reduce_seq: iterative a mod q by restoring shift-subtract, one dividend
// bit per clock, MSB first.
//   clock_i : rising-edge clock
//   reset_i : synchronous active-high reset; discards any in-flight operation
//   bus     : mod_reduce_seq_if.slave (operand and result valid/ready handshakes)
// Latency: A_WIDTH edges after acceptance; 1 edge when q == 0 (err_o set).
// Optional macro MOD_BYPASS_EN: operands with a < q (q != 0) skip RUN and
// complete in 1 edge with the dividend as the result.
module mod_reduce_seq #(
  parameter int A_WIDTH = 24,
  parameter int Q_WIDTH = 12
) (
  input logic            clock_i,
  input logic            reset_i,
  mod_reduce_seq_if.slave bus
);
  localparam int CNT_WIDTH = $clog2(A_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;
  state_t state_next;

  logic [A_WIDTH-1:0]   a_reg;
  logic [Q_WIDTH-1:0]   q_reg;
  logic [Q_WIDTH-1:0]   rem;
  logic [CNT_WIDTH-1:0] cnt;
  logic [Q_WIDTH-1:0]   amodq;
  logic                 err;

  logic [Q_WIDTH:0]     t;
  logic                 t_ge_q;
  logic [Q_WIDTH-1:0]   rem_next;
  logic                 last;
  logic                 q_zero;
  logic                 a_lt_q;

  // rem < q holds after every step, so it is kept at Q_WIDTH bits. The
  // compare uses the full Q_WIDTH+1-bit t; the difference is < q, so its low
  // Q_WIDTH bits are exact even though the subtraction is done at Q_WIDTH bits.
  assign t        = {rem, a_reg[A_WIDTH-1]};
  assign t_ge_q   = (t >= {1'b0, q_reg});
  assign rem_next = t_ge_q ? (t[Q_WIDTH-1:0] - q_reg) : t[Q_WIDTH-1:0];
  assign last     = (cnt == CNT_WIDTH'(A_WIDTH - 1));
  assign q_zero   = (bus.q_i == '0);
  assign a_lt_q   = (bus.a_i < A_WIDTH'(bus.q_i));

  always_ff @(posedge clock_i) begin
    if (reset_i) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.in_valid_i) begin
          if (q_zero) state_next = DONE;
`ifdef MOD_BYPASS_EN
          else if (a_lt_q) state_next = DONE;
`endif
          else state_next = RUN;
        end
      end
      RUN:     if (last) state_next = DONE;
      DONE:    if (bus.out_ready_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      a_reg <= '0;
      q_reg <= '0;
      rem   <= '0;
      cnt   <= '0;
      amodq <= '0;
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid_i) begin
            a_reg <= bus.a_i;
            q_reg <= bus.q_i;
            rem   <= '0;
            cnt   <= '0;
            amodq <= '0;
            err   <= q_zero;
`ifdef MOD_BYPASS_EN
            if (!q_zero && a_lt_q) amodq <= bus.a_i[Q_WIDTH-1:0];
`endif
          end
        end
        RUN: begin
          a_reg <= a_reg << 1;
          rem   <= rem_next;
          cnt   <= cnt + CNT_WIDTH'(1);
          if (last) amodq <= rem_next;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready_o  = (state == IDLE);
  assign bus.out_valid_o = (state == DONE);
  assign bus.amodq_o     = amodq;
  assign bus.err_o       = err;

`ifndef MOD_BYPASS_EN
  // a_lt_q only steers the bypass path; keep it observed in the default build.
  logic unused_bypass;
  assign unused_bypass = a_lt_q;
`endif
endmodule

// File: tb/tb_mod_reduce_seq.sv
// tb_mod_reduce_seq: directed self-checking bench for mod_reduce_seq
// (A_WIDTH=24, Q_WIDTH=12) with hand-computed remainders and latencies.
// Latency is counted as rising edges after the accepting edge; 0 means
// out_valid_o was already set by the accepting edge itself.
module tb_mod_reduce_seq;
  localparam int AW = 24;
  localparam int QW = 12;
`ifdef MOD_BYPASS_EN
  localparam int LAT_LT = 0;
`else
  localparam int LAT_LT = AW;
`endif

  logic clock_i = 1'b0;
  logic reset_i = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  mod_reduce_seq_if #(.A_WIDTH(AW), .Q_WIDTH(QW)) bus ();

  mod_reduce_seq #(.A_WIDTH(AW), .Q_WIDTH(QW)) dut (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .bus     (bus)
  );

  always #5 clock_i = ~clock_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [AW-1:0] a, input logic [QW-1:0] q,
                        input int hold, input logic [QW-1:0] exp_r, input logic exp_e,
                        input int exp_lat);
    int lat;
    logic [QW-1:0] res;
    check_eq({tag, "_rdy"}, 32'(bus.in_ready_o), 32'd1);
    bus.a_i = a;
    bus.q_i = q;
    bus.in_valid_i = 1'b1;
    bus.out_ready_i = (hold == 0);
    @(posedge clock_i); #1;
    bus.in_valid_i = 1'b0;
    bus.a_i = '1;
    bus.q_i = '1;
    lat = 0;
    while (!bus.out_valid_o && lat < 100) begin
      @(posedge clock_i); #1;
      lat++;
    end
    check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check_eq({tag, "_res"}, 32'(bus.amodq_o), 32'(exp_r));
    check_eq({tag, "_err"}, 32'(bus.err_o), 32'(exp_e));
    res = bus.amodq_o;
    for (int i = 0; i < hold; i++) begin
      @(posedge clock_i); #1;
      check_eq({tag, "_hold_vld"}, 32'(bus.out_valid_o), 32'd1);
      check_eq({tag, "_hold_res"}, 32'(bus.amodq_o), 32'(res));
      check_eq({tag, "_hold_rdy"}, 32'(bus.in_ready_o), 32'd0);
    end
    bus.out_ready_i = 1'b1;
    @(posedge clock_i); #1;
    check_eq({tag, "_vld_drop"}, 32'(bus.out_valid_o), 32'd0);
  endtask

  initial begin
    int seen;
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b1;
    bus.a_i = '0;
    bus.q_i = '0;
    repeat (2) @(posedge clock_i);
    #1 reset_i = 1'b0;
    @(posedge clock_i); #1;
    check_eq("rst_rdy", 32'(bus.in_ready_o), 32'd1);
    check_eq("rst_vld", 32'(bus.out_valid_o), 32'd0);
    check_eq("rst_res", 32'(bus.amodq_o), 32'd0);
    check_eq("rst_err", 32'(bus.err_o), 32'd0);

    run_op("basic",   24'd12345,    12'd3329, 0, 12'd2358, 1'b0, AW);
    run_op("sq",      24'd11075584, 12'd3329, 0, 12'd1,    1'b0, AW);
    run_op("allones", 24'd16777215, 12'd3329, 5, 12'd2384, 1'b0, AW);
    run_op("a_eq_q",  24'd3329,     12'd3329, 0, 12'd0,    1'b0, AW);
    run_op("qzero",   24'd500,      12'd0,    0, 12'd0,    1'b1, 0);
    run_op("after_e", 24'd7,        12'd5,    0, 12'd2,    1'b0, AW);
    run_op("a_lt_q",  24'd100,      12'd3329, 0, 12'd100,  1'b0, LAT_LT);
    run_op("a_zero",  24'd0,        12'd3329, 0, 12'd0,    1'b0, LAT_LT);
    run_op("q_one",   24'd12345,    12'd1,    0, 12'd0,    1'b0, AW);
    run_op("q_two",   24'd16777215, 12'd2,    0, 12'd1,    1'b0, AW);

    // Reset while RUN is at iteration 10.
    bus.a_i = 24'd12345;
    bus.q_i = 12'd3329;
    bus.in_valid_i = 1'b1;
    @(posedge clock_i); #1;
    bus.in_valid_i = 1'b0;
    repeat (10) @(posedge clock_i);
    #1 reset_i = 1'b1;
    @(posedge clock_i); #1;
    reset_i = 1'b0;
    check_eq("midrst_rdy", 32'(bus.in_ready_o), 32'd1);
    check_eq("midrst_vld", 32'(bus.out_valid_o), 32'd0);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clock_i); #1;
      if (bus.out_valid_o) seen++;
    end
    check_eq("midrst_noresult", 32'(seen), 32'd0);
    run_op("fresh", 24'd12345, 12'd3329, 0, 12'd2358, 1'b0, AW);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
